// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the shift-and-add multiplier sequencer.
package mult_sequencer_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_sequencer_adder_rc.sv
// Ripple-carry adder assembled from single-bit full-adder cells.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_rc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] c;

    assign c[0] = cin;
    assign cout = c[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fa_cell u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .sum (sum[i]),
            .cout(c[i+1])
        );
    end
endmodule

// File: rtl/mult_sequencer.sv
// Sequential unsigned multiplier: one conditional add-and-shift per RUN cycle
// through a single shared ripple-carry adder.
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] Product,
    output logic               Busy,
    output logic               Done
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state;
    logic [WIDTH-1:0] m, q, acc, addend, sum;
    logic            carry;
    logic [CW-1:0]   count;

    // Step counter increments with a half-adder chain so the datapath adder stays the only '+' path.
    function automatic logic [CW-1:0] incr(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          c;
        c = 1'b1;
        for (int i = 0; i < CW; i++) begin
            r[i] = v[i] ^ c;
            c    = v[i] & c;
        end
        return r;
    endfunction

    assign addend = q[0] ? m : '0;

    adder_rc #(.WIDTH(WIDTH)) u_adder (
        .a   (acc),
        .b   (addend),
        .cin (1'b0),
        .sum (sum),
        .cout(carry)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= IDLE;
            m       <= '0;
            q       <= '0;
            acc     <= '0;
            count   <= '0;
            Product <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        m     <= A;
                        q     <= B;
                        acc   <= '0;
                        count <= '0;
                        state <= RUN;
                        Busy  <= 1'b1;
                    end
                end
                RUN: begin
                    acc   <= {carry, sum[WIDTH-1:1]};
                    q     <= {sum[0], q[WIDTH-1:1]};
                    count <= incr(count);
                    // Final step: capture the shifted {Acc,Q} pair directly.
                    if (count == LAST) begin
                        Product <= {carry, sum, q[WIDTH-1:1]};
                        state   <= DONE;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_sequencer.sv
// Directed and randomized checks of mult_sequencer against an arithmetic reference.
module tb_mult_sequencer;
    localparam int W = 4;

    logic           Clock;
    logic           Resetn;
    logic           Start;
    logic [W-1:0]   A, B;
    logic [2*W-1:0] Product;
    logic           Busy, Done;

    int checks = 0;
    int errors = 0;

    mult_sequencer #(.WIDTH(W)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Start  (Start),
        .A      (A),
        .B      (B),
        .Product(Product),
        .Busy   (Busy),
        .Done   (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    // Issue one operation from IDLE and follow it to its Done pulse.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [2*W-1:0] exp, prev;
        int lat, busy_cnt;
        logic held, overlap;
        exp = ref_mul(a, b);
        prev = Product;
        A = a; B = b; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        lat = 0; busy_cnt = 0; held = 1'b1; overlap = 1'b0;
        while (!Done && lat < 20) begin
            if (Busy) busy_cnt++;
            if (Product !== prev) held = 1'b0;
            @(negedge Clock);
            lat++;
            if (Busy && Done) overlap = 1'b1;
        end
        check({tag, "_latency"}, lat, W);
        check({tag, "_busy_cycles"}, busy_cnt, W);
        check({tag, "_prev_held"}, held, 1'b1);
        check({tag, "_no_overlap"}, overlap, 1'b0);
        check({tag, "_product"}, Product, exp);
        check({tag, "_busy_at_done"}, Busy, 1'b0);
        @(negedge Clock);
        check({tag, "_done_one_cycle"}, Done, 1'b0);
        check({tag, "_product_hold"}, Product, exp);
    endtask

    initial begin
        int cyc, last_done, ndone, lowcnt, extra;
        logic [W-1:0] ra, rb;

        Resetn = 1'b0; Start = 1'b0; A = '0; B = '0;
        #1;
        check("reset_busy", Busy, 1'b0);
        check("reset_done", Done, 1'b0);
        check("reset_product", Product, 8'h00);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        check("idle_busy", Busy, 1'b0);

        do_op(4'd3, 4'd5, "op3x5");
        check("op3x5_const", Product, 8'h0F);
        do_op(4'd15, 4'd15, "op15x15");
        check("op15x15_const", Product, 8'hE1);
        do_op(4'd0, 4'd9, "op0x9");
        check("op0x9_const", Product, 8'h00);
        do_op(4'd9, 4'd1, "op9x1");
        check("op9x1_const", Product, 8'h09);

        // Start held high: Done every WIDTH+2 cycles, two Busy-low cycles between.
        A = 4'd2; B = 4'd7; Start = 1'b1;
        last_done = -1; ndone = 0; lowcnt = 0;
        for (cyc = 0; cyc < 22; cyc++) begin
            @(negedge Clock);
            check("held_no_overlap", Busy && Done, 1'b0);
            if (Done) begin
                check("held_product", Product, 8'h0E);
                if (last_done >= 0) begin
                    check("held_period", cyc - last_done, W + 2);
                    check("held_busy_low", lowcnt, 2);
                end
                ndone++;
                last_done = cyc;
                lowcnt = 0;
            end
            if (!Busy) lowcnt++;
        end
        check("held_done_count", ndone >= 3, 1'b1);
        Start = 1'b0;
        extra = 0;
        while ((Busy || Done) && extra < 20) begin
            @(negedge Clock);
            extra++;
        end
        check("held_back_to_idle", Busy || Done, 1'b0);
        @(negedge Clock);

        // Operand changes and Start during RUN must be ignored.
        A = 4'd6; B = 4'd6; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0; A = 4'd15; B = 4'd15;
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        extra = 0;
        while (!Done && extra < 20) begin
            @(negedge Clock);
            extra++;
        end
        check("ignore_done_seen", Done, 1'b1);
        check("ignore_product", Product, 8'h24);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            if (Done) ndone++;
        end
        check("ignore_single_done", ndone, 0);
        check("ignore_product_hold", Product, 8'h24);

        // Asynchronous reset in the second RUN cycle aborts without a Done.
        A = 4'd13; B = 4'd11; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        @(negedge Clock);
        check("pre_reset_busy", Busy, 1'b1);
        Resetn = 1'b0;
        #1;
        check("abort_busy", Busy, 1'b0);
        check("abort_done", Done, 1'b0);
        check("abort_product", Product, 8'h00);
        @(negedge Clock);
        Resetn = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            if (Done || Busy) ndone++;
        end
        check("abort_stays_idle", ndone, 0);
        check("abort_product_still0", Product, 8'h00);
        do_op(4'd4, 4'd3, "post_reset_4x3");
        check("post_reset_const", Product, 8'h0C);

        // Back-to-back: product moves E1 -> 01 and holds in between.
        do_op(4'd15, 4'd15, "b2b_first");
        repeat (3) @(negedge Clock);
        check("b2b_hold", Product, 8'hE1);
        do_op(4'd1, 4'd1, "b2b_second");
        check("b2b_second_const", Product, 8'h01);

        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            do_op(ra, rb, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port Resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port Start, input, 1 bit: multiply request, level-sampled.
REQ-005 The block SHALL have port A, input, WIDTH bits: multiplicand, unsigned.
REQ-006 The block SHALL have port B, input, WIDTH bits: multiplier, unsigned.
REQ-007 The block SHALL have port Product, output, 2*WIDTH bits: last completed product, registered.
REQ-008 The block SHALL have port Busy, output, 1 bit: high while the operation is in progress (RUN).
REQ-009 The block SHALL have port Done, output, 1 bit: one-cycle completion pulse.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-011 In IDLE, a rising edge with Start=1 SHALL perform these loads and go to RUN:
- M<=A, Q<=B;
- Acc<=0, Count<=0.
REQ-012 In IDLE with Start=0, the block SHALL remain in IDLE with all registers held.
REQ-013 Each RUN edge SHALL perform one step using a single shared WIDTH-bit ripple-carry adder with carry-in 0:
- {C,S} = Acc+M if Q[0]=1, else {0,Acc};
- Acc<={C,S[WIDTH-1:1]};
- Q<={S[0],Q[WIDTH-1:1]};
- Count<=Count+1.
REQ-014 On the RUN edge where Count=WIDTH-1, the block SHALL:
- load Product<= the post-shift {Acc,Q} (full 2*WIDTH result; no overflow possible);
- enter DONE.
REQ-015 In DONE, Done SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE unconditionally.
REQ-016 Latency: with Start sampled at edge 0, the block SHALL drive Done=1 and a valid Product during the cycle after edge WIDTH (4-bit operands: edge 4).
REQ-017 Issue rate: with Start held at 1, a new operation SHALL begin every WIDTH+2 edges.
REQ-018 Start SHALL be ignored in RUN and DONE, and no request SHALL be queued.
REQ-019 A and B SHALL be sampled only at the IDLE accept edge; changes to A or B during RUN SHALL NOT affect the result.
REQ-020 Product SHALL hold its value from one DONE entry until the next DONE entry.
REQ-021 Outputs by state:
- Busy=1 exactly when state=RUN;
- Done=1 exactly when state=DONE;
- Busy and Done SHALL never be high together.
REQ-022 Count SHALL be ceil(log2(WIDTH))+1 bits wide, and SHALL NOT wrap within an operation.

Reset
REQ-023 Resetn=0 SHALL, immediately and independent of Clock, set:
- state=IDLE;
- Product=0, Busy=0, Done=0;
- M, Q, Acc, C and Count to 0.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no Done pulse, and Product SHALL read 0.
REQ-025 After Resetn deasserts, the first rising edge with Start=1 SHALL start a fresh operation.

Structure
REQ-026 The FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL reside in a shared package, together with the WIDTH default constant.
REQ-027 The adder SHALL be one sub-module, adder_rc, with the following form:
- WIDTH-bit ripple-carry adder built from the team's full-adder cell;
- ports: operand a, operand b, carry-in, sum, carry-out;
- exactly one adder_rc instance, shared across all steps.
REQ-028 No multiplication operator SHALL be used, and all arithmetic SHALL pass through adder_rc.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- A=3, B=5, pulse Start -> Busy high for 4 cycles, then Done=1 for 1 cycle with Product=8'h0F.
- A=15, B=15 -> Product=8'hE1; A=0, B=9 -> 8'h00; A=9, B=1 -> 8'h09.
- Start held high with A=2, B=7 -> Done pulses every 6 cycles, Product=8'h0E each time, Busy low for 2 cycles between operations.
- A=6, B=6 accepted, then A/B changed to 15/15 and Start pulsed during RUN -> Product=8'h24, only one Done.
- Resetn=0 during the 2nd RUN cycle -> Busy=0 and Product=0 immediately, no Done; then A=4, B=3 -> Product=8'h0C.
- Back-to-back: 15×15 then 1×1 -> Product changes 8'hE1 to 8'h01, and holds between Done pulses.
